// File: rtl/load_store_unit.sv
// load_store_unit
// MEM-stage load/store initiator. Converts one load or store from the MEM
// pipeline register into a word-aligned data-memory request, waits for the
// completion, returns extended load data to writeback and raises address
// error (AdEL/AdES) and data bus error (DBE) exceptions. Stalls the pipeline
// while a transaction is outstanding.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   op_valid_i/op_i          memory instruction present / opcode[3:0]
//   addr_i/wdata_i/rd_i      effective address, store data, load destination
//   stall_o                  freeze IF/ID/EX/MEM
//   wb_valid_o/wb_rd_o/wb_data_o   one-cycle load writeback
//   exc_o/exc_code_o/badvaddr_o    one-cycle exception report
//   mem_*                    data-memory request/response port
//
// state | meaning
// IDLE  | waiting for a memory instruction
// REQ   | request driven, waiting for grant
// RESP  | granted, waiting for rvalid
// DONE  | completion cycle, load writeback pulse
// EXC   | exception pulse (misaligned or bus timeout)
module load_store_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        exc_o,
    output logic [4:0]  exc_code_o,
    output logic [31:0] badvaddr_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_DONE, S_EXC} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic [4:0]    exc_code_q, exc_code_d;
    logic [31:0]   badvaddr_q, badvaddr_d;

    logic          op_legal;
    logic          misaligned;
    logic          timeout;
    logic [31:0]   shifted;
    logic [31:0]   load_ext;

    always_comb begin
        op_legal = 1'b0;
        case (op_i)
            4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101,
            4'b1000, 4'b1001, 4'b1011: op_legal = 1'b1;
            default:                   op_legal = 1'b0;
        endcase
        // op_i[1:0] encodes access size: 00 byte, 01 half, 11 word
        misaligned = ((op_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((op_i[1:0] == 2'b11) && (addr_i[1:0] != 2'b00));
    end

    always_comb begin
        shifted = mem_rdata_i >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = uns_q ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    assign timeout = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wb_data_d  = wb_data_q;
        exc_code_d = exc_code_q;
        badvaddr_d = badvaddr_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid_i && op_legal) begin
                    if (misaligned) begin
                        exc_code_d = op_i[3] ? 5'd5 : 5'd4;
                        badvaddr_d = addr_i;
                        state_d    = S_EXC;
                    end else begin
                        we_d    = op_i[3];
                        size_d  = op_i[1:0];
                        uns_d   = op_i[2];
                        addr_d  = addr_i;
                        rd_d    = rd_i;
                        cnt_d   = '0;
                        case (op_i[1:0])
                            2'b00: begin
                                be_d    = 4'b0001 << addr_i[1:0];
                                wdata_d = {4{wdata_i[7:0]}};
                            end
                            2'b01: begin
                                be_d    = 4'b0011 << addr_i[1:0];
                                wdata_d = {2{wdata_i[15:0]}};
                            end
                            default: begin
                                be_d    = 4'b1111;
                                wdata_d = wdata_i;
                            end
                        endcase
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (timeout) begin
                    exc_code_d = 5'd7;
                    badvaddr_d = addr_q;
                    state_d    = S_EXC;
                end else if (mem_gnt_i) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cnt_d = cnt_q + 1'b1;
                // a completion on the last allowed cycle still wins
                if (mem_rvalid_i) begin
                    if (!we_q) begin
                        wb_data_d = load_ext;
                    end
                    state_d = S_DONE;
                end else if (timeout) begin
                    exc_code_d = 5'd7;
                    badvaddr_d = addr_q;
                    state_d    = S_EXC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_EXC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            wb_data_q  <= '0;
            exc_code_q <= '0;
            badvaddr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wb_data_q  <= wb_data_d;
            exc_code_q <= exc_code_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    assign stall_o     = (state_q == S_REQ) || (state_q == S_RESP) ||
                         ((state_q == S_IDLE) && op_valid_i && op_legal);
    assign wb_valid_o  = (state_q == S_DONE) && !we_q;
    assign wb_rd_o     = rd_q;
    assign wb_data_o   = wb_data_q;
    assign exc_o       = (state_q == S_EXC);
    assign exc_code_o  = exc_code_q;
    assign badvaddr_o  = badvaddr_q;
    assign mem_req_o   = (state_q == S_REQ);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = {addr_q[31:2], 2'b00};
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid_i = 1'b0;
    logic [3:0]  op_i = 4'b0;
    logic [31:0] addr_i = 32'b0;
    logic [31:0] wdata_i = 32'b0;
    logic [4:0]  rd_i = 5'b0;
    logic        stall_o;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        exc_o;
    logic [4:0]  exc_code_o;
    logic [31:0] badvaddr_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'b0;

    int checks = 0;
    int failures = 0;

    load_store_unit #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .op_valid_i(op_valid_i), .op_i(op_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rd_i(rd_i),
        .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .exc_o(exc_o), .exc_code_o(exc_code_o),
        .badvaddr_o(badvaddr_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait transaction driver: accept, REQ (gnt), RESP (rvalid), DONE, IDLE.
    // Returns what was observed on the request and writeback sides.
    task automatic drive_zero_wait(
        input  logic [3:0]  op, input logic [31:0] addr, input logic [31:0] wdata,
        input  logic [4:0]  rd, input logic [31:0] rdata,
        output logic        o_req, output logic o_we, output logic [31:0] o_addr,
        output logic [3:0]  o_be, output logic [31:0] o_wdata,
        output logic        o_wb_valid, output logic [31:0] o_wb_data,
        output logic [4:0]  o_wb_rd, output int o_stalls, output logic o_wb_after);
        op_valid_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wdata; rd_i = rd;
        o_stalls = 0;
        #1;
        if (stall_o) o_stalls++;
        step();
        o_req = mem_req_o; o_we = mem_we_o; o_addr = mem_addr_o;
        o_be = mem_be_o; o_wdata = mem_wdata_o;
        if (stall_o) o_stalls++;
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        if (stall_o) o_stalls++;
        mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
        step();
        mem_rvalid_i = 1'b0;
        if (stall_o) o_stalls++;
        o_wb_valid = wb_valid_o; o_wb_data = wb_data_o; o_wb_rd = wb_rd_o;
        op_valid_i = 1'b0;
        step();
        o_wb_after = wb_valid_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if ({stall_o, wb_valid_o, exc_o, mem_req_o, mem_we_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {stall_o, wb_valid_o, exc_o, mem_req_o, mem_we_o});
        end
        checks++;
        if ({mem_be_o, mem_addr_o, mem_wdata_o, wb_data_o, badvaddr_o, exc_code_o, wb_rd_o} !== '0) begin
            failures++;
            $display("FAIL reset_data: be=%h addr=%h wdata=%h wb=%h bad=%h code=%0d rd=%0d want all 0",
                     mem_be_o, mem_addr_o, mem_wdata_o, wb_data_o, badvaddr_o, exc_code_o, wb_rd_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_lw();
        logic req, we, wbv, wba; logic [31:0] a, wd, wbd; logic [3:0] be; logic [4:0] wr; int st;
        drive_zero_wait(4'b0011, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF,
                        req, we, a, be, wd, wbv, wbd, wr, st, wba);
        checks++;
        if ({req, we, be} !== 6'b10_1111) begin
            failures++; $display("FAIL lw_req: req/we/be got %b want 101111", {req, we, be});
        end
        checks++;
        if (a !== 32'h100) begin
            failures++; $display("FAIL lw_addr: got %h want 00000100", a);
        end
        checks++;
        if (wbv !== 1'b1 || wbd !== 32'hDEADBEEF || wr !== 5'd5) begin
            failures++; $display("FAIL lw_wb: valid=%b data=%h rd=%0d want 1 deadbeef 5", wbv, wbd, wr);
        end
        checks++;
        if (st !== 3) begin
            failures++; $display("FAIL lw_stall_cycles: got %0d want 3", st);
        end
        checks++;
        if (wba !== 1'b0) begin
            failures++; $display("FAIL lw_wb_one_cycle: got %b want 0", wba);
        end
    endtask

    task automatic test_load_extend();
        logic req, we, wbv, wba; logic [31:0] a, wd, wbd; logic [3:0] be; logic [4:0] wr; int st;
        logic [3:0]  ops  [5] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0011};
        logic [31:0] adrs [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h104};
        logic [4:0]  rds  [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd0};
        logic [3:0]  bes  [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111};
        logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011,
                                  32'h00008011, 32'h80112233};
        for (int i = 0; i < 5; i++) begin
            drive_zero_wait(ops[i], adrs[i], 32'h0, rds[i], 32'h80112233,
                            req, we, a, be, wd, wbv, wbd, wr, st, wba);
            checks++;
            if (be !== bes[i] || a !== {adrs[i][31:2], 2'b00}) begin
                failures++;
                $display("FAIL ld_be[%0d]: be=%b addr=%h want %b %h", i, be, a, bes[i],
                         {adrs[i][31:2], 2'b00});
            end
            checks++;
            if (wbv !== 1'b1 || wbd !== exps[i] || wr !== rds[i]) begin
                failures++;
                $display("FAIL ld_data[%0d]: valid=%b data=%h rd=%0d want 1 %h %0d",
                         i, wbv, wbd, wr, exps[i], rds[i]);
            end
        end
    endtask

    task automatic test_store();
        logic req, we, wbv, wba; logic [31:0] a, wd, wbd; logic [3:0] be; logic [4:0] wr; int st;
        logic [3:0]  ops  [3] = '{4'b1001, 4'b1000, 4'b1011};
        logic [31:0] adrs [3] = '{32'h102, 32'h101, 32'h208};
        logic [31:0] wds  [3] = '{32'h0000ABCD, 32'h1234565A, 32'hCAFEF00D};
        logic [3:0]  bes  [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] expw [3] = '{32'hABCDABCD, 32'h5A5A5A5A, 32'hCAFEF00D};
        for (int i = 0; i < 3; i++) begin
            drive_zero_wait(ops[i], adrs[i], wds[i], 5'd9, 32'h0,
                            req, we, a, be, wd, wbv, wbd, wr, st, wba);
            checks++;
            if (req !== 1'b1 || we !== 1'b1 || be !== bes[i] || wd !== expw[i]) begin
                failures++;
                $display("FAIL st_req[%0d]: req=%b we=%b be=%b wdata=%h want 1 1 %b %h",
                         i, req, we, be, wd, bes[i], expw[i]);
            end
            checks++;
            if (wbv !== 1'b0 || st !== 3) begin
                failures++;
                $display("FAIL st_done[%0d]: wb_valid=%b stalls=%0d want 0 3", i, wbv, st);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [3:0]  ops  [2] = '{4'b0001, 4'b1011};
        logic [31:0] adrs [2] = '{32'h101, 32'h206};
        logic [4:0]  code [2] = '{5'd4, 5'd5};
        logic        saw_req;
        for (int i = 0; i < 2; i++) begin
            op_valid_i = 1'b1; op_i = ops[i]; addr_i = adrs[i]; wdata_i = 32'h55; rd_i = 5'd3;
            #1;
            saw_req = mem_req_o;
            checks++;
            if (stall_o !== 1'b1) begin
                failures++; $display("FAIL mis_accept_stall[%0d]: got %b want 1", i, stall_o);
            end
            step();
            saw_req = saw_req | mem_req_o;
            checks++;
            if (exc_o !== 1'b1 || exc_code_o !== code[i] || badvaddr_o !== adrs[i] || stall_o !== 1'b0) begin
                failures++;
                $display("FAIL mis_exc[%0d]: exc=%b code=%0d bad=%h stall=%b want 1 %0d %h 0",
                         i, exc_o, exc_code_o, badvaddr_o, stall_o, code[i], adrs[i]);
            end
            op_valid_i = 1'b0;
            step();
            saw_req = saw_req | mem_req_o;
            checks++;
            if (exc_o !== 1'b0 || saw_req !== 1'b0) begin
                failures++;
                $display("FAIL mis_after[%0d]: exc=%b any_req=%b want 0 0", i, exc_o, saw_req);
            end
        end
    endtask

    task automatic test_illegal_op();
        op_valid_i = 1'b1; op_i = 4'b0010; addr_i = 32'h100;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            failures++; $display("FAIL illegal_stall: got %b want 0", stall_o);
        end
        step();
        checks++;
        if (mem_req_o !== 1'b0 || exc_o !== 1'b0) begin
            failures++; $display("FAIL illegal_ignored: req=%b exc=%b want 0 0", mem_req_o, exc_o);
        end
        op_valid_i = 1'b0;
        step();
    endtask

    task automatic test_wait_states();
        int  req_cycles = 0;
        logic stable = 1'b1;
        op_valid_i = 1'b1; op_i = 4'b0011; addr_i = 32'h204; rd_i = 5'd7;
        step();
        for (int i = 0; i < 4; i++) begin
            mem_gnt_i    = (i == 3);
            mem_rvalid_i = (i == 3);
            mem_rdata_i  = (i == 3) ? 32'hBAD0BAD0 : 32'h0;
            #1;
            if (mem_req_o) req_cycles++;
            if (mem_addr_o !== 32'h204 || mem_be_o !== 4'b1111 || mem_we_o !== 1'b0) stable = 1'b0;
            step();
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b1 || wb_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL ws_resp: req=%b stall=%b wb=%b want 0 1 0", mem_req_o, stall_o, wb_valid_o);
        end
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h12345678;
        step();
        mem_rvalid_i = 1'b0;
        checks++;
        if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h12345678 || wb_rd_o !== 5'd7) begin
            failures++;
            $display("FAIL ws_wb: valid=%b data=%h rd=%0d want 1 12345678 7", wb_valid_o, wb_data_o, wb_rd_o);
        end
        checks++;
        if (req_cycles !== 4 || stable !== 1'b1) begin
            failures++;
            $display("FAIL ws_req: req_cycles=%0d stable=%b want 4 1", req_cycles, stable);
        end
        op_valid_i = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int n;
        op_valid_i = 1'b1; op_i = 4'b0011; addr_i = 32'h300; rd_i = 5'd9;
        step();
        mem_gnt_i = 1'b1; n = 1;
        step();
        mem_gnt_i = 1'b0; n = 2;
        while (!exc_o && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n !== 9) begin
            failures++; $display("FAIL to_latency: exc after %0d cycles want 9", n);
        end
        checks++;
        if (exc_o !== 1'b1 || exc_code_o !== 5'd7 || badvaddr_o !== 32'h300 || mem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL to_exc: exc=%b code=%0d bad=%h req=%b want 1 7 00000300 0",
                     exc_o, exc_code_o, badvaddr_o, mem_req_o);
        end
        op_valid_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFEEDFACE;
        step();
        step();
        mem_rvalid_i = 1'b0;
        checks++;
        if (wb_valid_o !== 1'b0 || exc_o !== 1'b0 || stall_o !== 1'b0 || wb_data_o === 32'hFEEDFACE) begin
            failures++;
            $display("FAIL to_late_rvalid: wb=%b exc=%b stall=%b data=%h want 0 0 0 not feedface",
                     wb_valid_o, exc_o, stall_o, wb_data_o);
        end
    endtask

    task automatic test_reset_in_resp();
        op_valid_i = 1'b1; op_i = 4'b0011; addr_i = 32'h400; rd_i = 5'd2;
        step();
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        rst = 1'b1; op_valid_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11112222;
        step();
        rst = 1'b0; mem_rvalid_i = 1'b0;
        checks++;
        if ({stall_o, mem_req_o, wb_valid_o, exc_o} !== 4'b0 || mem_be_o !== 4'b0) begin
            failures++;
            $display("FAIL rst_resp: stall=%b req=%b wb=%b exc=%b be=%b want 0 0 0 0 0000",
                     stall_o, mem_req_o, wb_valid_o, exc_o, mem_be_o);
        end
        step();
        checks++;
        if (wb_valid_o !== 1'b0 || exc_o !== 1'b0 || mem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_resp_after: wb=%b exc=%b req=%b want 0 0 0", wb_valid_o, exc_o, mem_req_o);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_extend();
        test_store();
        test_misaligned();
        test_illegal_op();
        test_wait_states();
        test_timeout();
        test_reset_in_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
